sync_fifo_rd_stream: RTL and testbench
======================================

Name: sync_fifo_rd_stream

Overview:
- Read-side adapter placed directly downstream of a synchronous FIFO whose read data is registered: `data_out` is valid the cycle after `ren` and holds until the next `ren`.
- Converts the FIFO's `ren`/`empty`/`data_out` interface into a valid/ready stream with registered outputs.
- Uses a 2-entry output buffer so the stream runs at full throughput (one beat per cycle) despite the 1-cycle FIFO read latency.
- Consumer side may apply arbitrary backpressure without losing or duplicating data.

Parameters:
- T, logic, payload type; must match the upstream FIFO's element type.

Ports:
- `clk`, input, 1, rising-edge clock shared with the upstream FIFO.
- `rst`, input, 1, synchronous active-high reset.
- `fifo_ren`, output, 1, read enable to the FIFO; combinational.
- `fifo_data`, input, T, FIFO read data; valid the cycle after `fifo_ren`.
- `fifo_empty`, input, 1, FIFO empty flag; high means no entry may be read this cycle.
- `m_valid`, output, 1, stream data valid; registered.
- `m_data`, output, T, stream payload; registered, equals the head buffer entry.
- `m_ready`, input, 1, downstream accept.
- `level`, output, 2, buffered entries plus in-flight read (0..2); registered.

Behaviour:
- **State**
  - `buf[0..1]`: 2-entry circular buffer of T.
  - `wr_ptr`, `rd_ptr`: 1 bit each.
  - `cnt`: 0..2, entries held in the buffer.
  - `inflight`: 1 bit, a `fifo_ren` was issued last cycle.
  - `level = cnt + inflight`, never exceeds 2.
- **Reset** (`rst` high at a clock edge)
  - `cnt`, `inflight`, `wr_ptr`, `rd_ptr` go to 0.
  - `m_valid` = 0, `level` = 0; `m_data` contents don't-care.
  - `fifo_ren` is forced 0 while `rst` is high.
  - An in-flight read is discarded. The FIFO must be reset in the same cycle, so no entry is orphaned.
- **Definitions**
  - `pop = m_valid & m_ready`.
  - `fifo_ren = !rst & !fifo_empty & ((cnt + inflight - pop) < 2)`.
  - The pop in the same cycle frees a slot, so steady-state throughput is 1/cycle.
- **Capture**
  - When `inflight` = 1, `fifo_data` is written to `buf[wr_ptr]`; `wr_ptr` toggles.
  - Capture happens every such cycle regardless of `m_ready`. The credit rule guarantees space.
- **Pop**
  - On `pop`, `rd_ptr` toggles.
  - `cnt_next = cnt + inflight - pop`.
  - `inflight_next = fifo_ren`.
- **Outputs**
  - `m_valid` = (`cnt` > 0); `m_data` = `buf[rd_ptr]`.
  - Both are presented from registered state only; no combinational path from `m_ready` or `fifo_data` to any stream output.
- **Latency**
  - Empty pipeline to first beat: `fifo_empty` falls in cycle N, `fifo_ren` = 1 in cycle N, capture at edge N+1, `m_valid` = 1 in cycle N+2.
- **Boundary conditions**
  - `cnt` = 2, `inflight` = 0, no pop: `fifo_ren` = 0.
  - `cnt` = 2 with pop: `fifo_ren` may be 1; the new beat lands in the freed slot.
  - `cnt` = 1, `inflight` = 1, no pop: `fifo_ren` = 0; next cycle `cnt` = 2.
  - Simultaneous capture and pop at `cnt` = 1: `cnt` stays 1; head advances to the captured entry.
  - `fifo_empty` high: no read issued. A read already in flight still completes.
  - Once `m_valid` is asserted, `m_data` and `m_valid` stay stable until `pop`.
- **Assertions** (bench)
  - `level` ≤ 2.
  - No capture when `cnt` = 2 without a same-cycle pop.
  - `m_data` stable while `m_valid` & !`m_ready`.

Test Plan (T = logic [7:0]):
- **Reset:** hold `rst` 3 cycles with `fifo_empty` = 0 → `fifo_ren` = 0, `m_valid` = 0, `level` = 0 throughout. First `fifo_ren` in the cycle after `rst` falls.
- **Streaming:** FIFO preloaded 0x10..0x17, `m_ready` = 1 → `m_valid` rises 2 cycles after first `fifo_ren`. Eight consecutive beats 0x10..0x17, no bubbles; `fifo_ren` high for 8 consecutive cycles.
- **Backpressure:** FIFO holds 0xA0..0xA5, `m_ready` = 0 → exactly 2 `fifo_ren` pulses. Then `level` = 2, `m_data` = 0xA0 held stable. Release `m_ready` → 0xA0..0xA5 delivered in order, no loss or duplicates.
- **Toggling ready:** `m_ready` toggles 1,0,1,0 over 12 entries 0x00..0x0B → all 12 delivered in order. `level` never exceeds 2; 0x05 stays on `m_data` until accepted.
- **Sparse input:** single entry 0x55 written, then `fifo_empty` stays high → one `fifo_ren`, one beat 0x55. Afterwards `m_valid` = 0, `level` = 0.
- **Reset mid-operation:** `level` = 2 with `inflight` = 1 (FIFO entries 0x30..0x33), assert `rst` together with the FIFO reset for 1 cycle → next cycle `m_valid` = 0, `level` = 0. No stale 0x30–0x33 appears after new entry 0x77 is written and streamed.

Source files
------------

// File: rtl/sync_fifo_rd_stream.sv
// Read-side adapter for a FIFO with registered read data: issues fifo_ren on
// credit and re-times the returned data into a 2-entry buffer feeding a valid/ready stream.
module sync_fifo_rd_stream #(
  parameter type T = logic
) (
  input  logic       clk,
  input  logic       rst,
  output logic       fifo_ren,
  input  T           fifo_data,
  input  logic       fifo_empty,
  output logic       m_valid,
  output T           m_data,
  input  logic       m_ready,
  output logic [1:0] level
);

  // Stream handshake: a beat transfers on a rising clk edge where m_valid & m_ready
  // are both high; once m_valid rises, m_valid and m_data hold until that transfer.

  T           buf_mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic       inflight;
  logic       pop;
  logic [1:0] occ_after_pop;

  assign pop = m_valid & m_ready;

  // A read may issue only if buffered + in-flight entries, after this cycle's pop,
  // leave a free slot; counting the pop is what sustains one beat per cycle.
  assign occ_after_pop = cnt + {1'b0, inflight} - {1'b0, pop};
  assign fifo_ren      = !rst && !fifo_empty && (occ_after_pop < 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 2'd0;
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      cnt      <= occ_after_pop;
      inflight <= fifo_ren;
      if (inflight) wr_ptr <= !wr_ptr;
      if (pop)      rd_ptr <= !rd_ptr;
    end
  end

  // Data that was read the previous cycle always lands; the credit rule guarantees the slot.
  always_ff @(posedge clk) begin
    if (!rst && inflight) buf_mem[wr_ptr] <= fifo_data;
  end

  assign m_valid = (cnt != 2'd0);
  assign m_data  = buf_mem[rd_ptr];
  assign level   = cnt + {1'b0, inflight};

endmodule

// File: tb/tb_sync_fifo_rd_stream.sv
// Directed bench for sync_fifo_rd_stream: behavioural registered-read FIFO upstream,
// scoreboard on the stream side, hand-computed window expectations per phase.
module tb_sync_fifo_rd_stream;

  typedef logic [7:0] data_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_ren;
  data_t      fifo_data;
  logic       fifo_empty;
  logic       m_valid;
  data_t      m_data;
  logic       m_ready;
  logic [1:0] level;

  logic       fifo_clr;
  data_t      fifo_mem [256];
  logic [7:0] wr_idx;
  logic [7:0] rd_idx;

  data_t      exp_q[$];
  data_t      exp_d;
  int         total = 0;
  int         bad = 0;
  logic       prev_hold = 1'b0;
  data_t      prev_data;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  sync_fifo_rd_stream #(.T(data_t)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_ren   (fifo_ren),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .level      (level)
  );

  // ---------------- upstream FIFO model (data valid the cycle after ren) ----------------
  assign fifo_empty = (rd_idx == wr_idx);

  always @(posedge clk) begin
    if (fifo_clr) begin
      rd_idx <= wr_idx;
    end else if (fifo_ren === 1'b1) begin
      fifo_data <= fifo_mem[rd_idx];
      rd_idx    <= rd_idx + 8'd1;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and per-cycle invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("level_le_2", 32'(level <= 2'd2), 32'd1);
      if (prev_hold) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_d = exp_q.pop_front();
          check("beat_data", 32'(m_data), 32'(exp_d));
        end
      end
      prev_hold <= (m_valid === 1'b1) && (m_ready === 1'b0);
      prev_data <= m_data;
    end else begin
      prev_hold <= 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input data_t d);
    fifo_mem[wr_idx] = d;
    wr_idx = wr_idx + 8'd1;
    exp_q.push_back(d);
  endtask

  // Observes n cycles; starts and ends just after a rising edge.
  task automatic run_window(input int n, input bit toggle,
                            output int ren_n, output int first_ren, output int last_ren,
                            output int beat_n, output int first_beat, output int last_beat);
    ren_n = 0; first_ren = -1; last_ren = -1;
    beat_n = 0; first_beat = -1; last_beat = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (fifo_ren === 1'b1) begin
        if (first_ren < 0) first_ren = i;
        last_ren = i;
        ren_n++;
      end
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        if (first_beat < 0) first_beat = i;
        last_beat = i;
        beat_n++;
      end
      @(posedge clk);
      #1;
      if (toggle) m_ready = !m_ready;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rn, fr, lr, bn, fb, lb;

    rst      = 1'b1;
    m_ready  = 1'b1;
    fifo_clr = 1'b1;
    wr_idx   = 8'd0;
    @(posedge clk);
    #1;
    fifo_clr = 1'b0;

    // Reset: FIFO non-empty but no read and no output while rst is high.
    for (int i = 0; i < 8; i++) push(data_t'(8'h10 + i));
    repeat (3) begin
      @(negedge clk);
      check("rst_ren", 32'(fifo_ren), 32'd0);
      check("rst_valid", 32'(m_valid), 32'd0);
      check("rst_level", 32'(level), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming: 8 reads back to back, beats start 2 cycles later with no bubbles.
    run_window(14, 1'b0, rn, fr, lr, bn, fb, lb);
    check("stream_first_ren", 32'(fr), 32'd0);
    check("stream_ren_n", 32'(rn), 32'd8);
    check("stream_last_ren", 32'(lr), 32'd7);
    check("stream_first_beat", 32'(fb), 32'd2);
    check("stream_beat_n", 32'(bn), 32'd8);
    check("stream_last_beat", 32'(lb), 32'd9);
    @(negedge clk);
    check("stream_idle_valid", 32'(m_valid), 32'd0);
    check("stream_idle_level", 32'(level), 32'd0);
    check("stream_sb_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;

    // Backpressure: only two reads fit, head holds 0xA0.
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(data_t'(8'hA0 + i));
    run_window(8, 1'b0, rn, fr, lr, bn, fb, lb);
    check("bp_ren_n", 32'(rn), 32'd2);
    check("bp_beat_n", 32'(bn), 32'd0);
    @(negedge clk);
    check("bp_level", 32'(level), 32'd2);
    check("bp_valid", 32'(m_valid), 32'd1);
    check("bp_data", 32'(m_data), 32'hA0);
    check("bp_full_no_ren", 32'(fifo_ren), 32'd0);
    @(posedge clk);
    #1;
    run_window(3, 1'b0, rn, fr, lr, bn, fb, lb);
    check("bp_hold_ren_n", 32'(rn), 32'd0);
    @(negedge clk);
    check("bp_hold_data", 32'(m_data), 32'hA0);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    run_window(10, 1'b0, rn, fr, lr, bn, fb, lb);
    check("bp_rel_ren_on_pop", 32'(fr), 32'd0);
    check("bp_rel_ren_n", 32'(rn), 32'd4);
    check("bp_rel_beat_n", 32'(bn), 32'd6);
    check("bp_rel_first_beat", 32'(fb), 32'd0);
    check("bp_rel_last_beat", 32'(lb), 32'd5);
    @(negedge clk);
    check("bp_idle_level", 32'(level), 32'd0);
    check("bp_sb_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;

    // Toggling ready over 12 entries.
    m_ready = 1'b1;
    for (int i = 0; i < 12; i++) push(data_t'(i));
    run_window(40, 1'b1, rn, fr, lr, bn, fb, lb);
    check("tog_ren_n", 32'(rn), 32'd12);
    check("tog_beat_n", 32'(bn), 32'd12);
    @(negedge clk);
    check("tog_idle_level", 32'(level), 32'd0);
    check("tog_sb_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;

    // Sparse input: a single entry, then the FIFO stays empty.
    m_ready = 1'b1;
    push(8'h55);
    run_window(8, 1'b0, rn, fr, lr, bn, fb, lb);
    check("sparse_ren_n", 32'(rn), 32'd1);
    check("sparse_beat_n", 32'(bn), 32'd1);
    check("sparse_latency", 32'(fb - fr), 32'd2);
    @(negedge clk);
    check("sparse_valid", 32'(m_valid), 32'd0);
    check("sparse_level", 32'(level), 32'd0);
    @(posedge clk);
    #1;

    // Reset mid-operation with one entry buffered and one read in flight.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(data_t'(8'h30 + i));
    run_window(2, 1'b0, rn, fr, lr, bn, fb, lb);
    check("mid_ren_n", 32'(rn), 32'd2);
    rst      = 1'b1;
    fifo_clr = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_ren", 32'(fifo_ren), 32'd0);
    check("mid_pre_level", 32'(level), 32'd2);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    fifo_clr = 1'b0;
    @(negedge clk);
    check("mid_post_valid", 32'(m_valid), 32'd0);
    check("mid_post_level", 32'(level), 32'd0);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    push(8'h77);
    run_window(8, 1'b0, rn, fr, lr, bn, fb, lb);
    check("mid_new_ren_n", 32'(rn), 32'd1);
    check("mid_new_beat_n", 32'(bn), 32'd1);
    @(negedge clk);
    check("mid_idle_level", 32'(level), 32'd0);
    check("mid_sb_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
